// File: rtl/pipe_window_acc.sv
// Windowed sum/min/max accumulator: collects up to 2**LOG2W unsigned samples
// and hands the window statistics to a consumer through a valid/ready hold stage.
module pipe_window_acc #(
  parameter int N     = 10,
  parameter int LOG2W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  output logic [N+LOG2W-1:0] out_sum,
  output logic [N-1:0]       out_min,
  output logic [N-1:0]       out_max,
  output logic [LOG2W:0]     out_cnt,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int SW = N + LOG2W;
  localparam int CW = LOG2W + 1;
  localparam logic [CW-1:0] WIN_LEN = CW'(1 << LOG2W);

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [N-1:0]  min_q, min_d;
  logic [N-1:0]  max_q, max_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;
  logic          emit;
  logic          take;

  // Driven from the state register only, so in_ready has no path from any input.
  assign in_ready = (state_q == ACC);

  // Running statistics including any sample accepted this cycle; these are
  // what a same-cycle emission must latch.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    accept = in_valid && (state_q == ACC);
    sum_d  = sum_q;
    min_d  = min_q;
    max_d  = max_q;
    cnt_d  = cnt_q;
    if (accept) begin
      sum_d = sum_q + SW'(in_data);
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == '0) begin
        min_d = in_data;
        max_d = in_data;
      end else begin
        min_d = (in_data < min_q) ? in_data : min_q;
        max_d = (in_data > max_q) ? in_data : max_q;
      end
    end
    emit = (state_q == ACC) && ((cnt_d == WIN_LEN) || (flush && (cnt_d != '0)));
    take = (state_q == HOLD) && out_ready;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACC:     if (emit) state_d = HOLD;
      HOLD:    if (take) state_d = ACC;
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) state_q <= ACC;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q     <= '0;
      min_q     <= '0;
      max_q     <= '0;
      cnt_q     <= '0;
      out_sum   <= '0;
      out_min   <= '0;
      out_max   <= '0;
      out_cnt   <= '0;
      out_valid <= 1'b0;
    end else if (take) begin
      sum_q     <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
    end else if (state_q == ACC) begin
      sum_q <= sum_d;
      min_q <= min_d;
      max_q <= max_d;
      cnt_q <= cnt_d;
      if (emit) begin
        out_sum   <= sum_d;
        out_min   <= min_d;
        out_max   <= max_d;
        out_cnt   <= cnt_d;
        out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_window_acc.sv
// Directed self-checking bench for pipe_window_acc with hand-computed windows.
module tb_pipe_window_acc;

  localparam int N     = 10;
  localparam int LOG2W = 3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N-1:0]       in_data;
  logic               in_valid;
  logic               in_ready;
  logic               flush;
  logic [N+LOG2W-1:0] out_sum;
  logic [N-1:0]       out_min;
  logic [N-1:0]       out_max;
  logic [LOG2W:0]     out_cnt;
  logic               out_valid;
  logic               out_ready;

  int total = 0;
  int bad   = 0;

  pipe_window_acc #(.N(N), .LOG2W(LOG2W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_sum   (out_sum),
    .out_min   (out_min),
    .out_max   (out_max),
    .out_cnt   (out_cnt),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [N-1:0] v);
    in_valid = 1'b1;
    in_data  = v;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_out(input string tag, input int s, input int mn, input int mx, input int c);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_sum"},   32'(out_sum),   32'(s));
    check({tag, "_min"},   32'(out_min),   32'(mn));
    check({tag, "_max"},   32'(out_max),   32'(mx));
    check({tag, "_cnt"},   32'(out_cnt),   32'(c));
    check({tag, "_rdy"},   32'(in_ready),  32'd0);
  endtask

  // Consumer takes the held result; block is back in ACC afterwards.
  task automatic drain(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_drain_rdy"},   32'(in_ready),  32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_rdy",   32'(in_ready),  32'd1);
    check("rst_sum",   32'(out_sum),   32'd0);
    check("rst_cnt",   32'(out_cnt),   32'd0);
    rst_n = 1'b1;
    tick();

    // Full window with the consumer always ready.
    out_ready = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      send(N'(10 * i));
      check("full_no_early_valid", 32'(out_valid), 32'd0);
    end
    send(N'(80));
    out_ready = 1'b0;
    check_out("full", 360, 10, 80, 8);
    drain("full");

    // Backpressure: result held, stalled sample 99 waits for ACC.
    for (int i = 1; i <= 8; i++) send(N'(10 * i));
    in_valid = 1'b1;
    in_data  = N'(99);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out("bp_hold", 360, 10, 80, 8);
    end
    drain("bp");
    tick();
    in_valid = 1'b0;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    check_out("bp_99", 99, 99, 99, 1);
    drain("bp_99");

    // Flush with a same-cycle sample, then flush of an empty window.
    send(N'(5));
    send(N'(7));
    flush = 1'b1;
    send(N'(2));
    flush = 1'b0;
    check_out("flush", 14, 2, 7, 3);
    flush = 1'b1;
    tick();
    check("flush_in_hold_valid", 32'(out_valid), 32'd1);
    check("flush_in_hold_sum",   32'(out_sum),   32'd14);
    flush = 1'b0;
    drain("flush");
    flush = 1'b1;
    tick();
    tick();
    flush = 1'b0;
    check("flush_empty_valid", 32'(out_valid), 32'd0);
    check("flush_empty_rdy",   32'(in_ready),  32'd1);

    // Width extremes.
    for (int i = 0; i < 8; i++) send(N'(1023));
    check_out("max_win", 8184, 1023, 1023, 8);
    drain("max_win");
    for (int i = 0; i < 8; i++) send(N'(0));
    check_out("zero_win", 0, 0, 0, 8);
    drain("zero_win");

    // Reset mid-window discards the partial window.
    for (int i = 0; i < 4; i++) send(N'(9));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_rdy",   32'(in_ready),  32'd1);
    for (int i = 0; i < 8; i++) send(N'(3));
    check_out("midrst", 24, 3, 3, 8);
    drain("midrst");

    // Reset during HOLD, then a clean window.
    for (int i = 0; i < 8; i++) send(N'(100));
    check_out("holdrst_pre", 800, 100, 100, 8);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("holdrst_valid", 32'(out_valid), 32'd0);
    check("holdrst_sum",   32'(out_sum),   32'd0);
    check("holdrst_rdy",   32'(in_ready),  32'd1);
    for (int i = 8; i >= 1; i--) send(N'(i));
    check_out("holdrst_win", 36, 1, 8, 8);
    drain("holdrst_win");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_window_acc.md
PIPE_WINDOW_ACC -- requirements
Module: pipe_window_acc

Interface
REQ-001 Parameter N, default 10, SHALL set the sample width and match the upstream pipeline result width.
REQ-002 Parameter LOG2W, default 3, SHALL set the window length W = 2**LOG2W samples.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst_n  input  1  SHALL be the synchronous, active-low reset, sampled on rising clk.
REQ-005 in_data  input  N  SHALL carry an unsigned pipeline result sample.
REQ-006 in_valid  input  1  SHALL indicate that in_data holds a valid sample.
REQ-007 in_ready  output  1  SHALL indicate that the block accepts a sample this cycle.
REQ-008 flush  input  1  SHALL request early emission of a partial window.
REQ-009 out_sum  output  N+LOG2W  SHALL carry the window sum.
REQ-010 out_min  output  N  SHALL carry the window minimum.
REQ-011 out_max  output  N  SHALL carry the window maximum.
REQ-012 out_cnt  output  LOG2W+1  SHALL carry the number of samples in the emitted window (1..W).
REQ-013 out_valid  output  1  SHALL indicate that the out_* result is valid.
REQ-014 out_ready  input  1  SHALL indicate that the consumer takes the result this cycle.

Function
REQ-015 The block SHALL implement two states: ACC (collecting) and HOLD (result pending).
REQ-016 in_ready SHALL be 1 in ACC and 0 in HOLD.
REQ-017 A sample SHALL be accepted only on a rising edge where in_valid and in_ready are both 1.
REQ-018 On each accepted sample: sum += in_data; min = lesser of min and in_data; max = greater of max and in_data; cnt += 1.
REQ-019 The first sample of a window SHALL load min and max directly, ignoring their prior contents.
REQ-020 When the accepted sample makes cnt equal W, the block SHALL latch sum/min/max/cnt into out_* and enter HOLD; out_valid SHALL go to 1 on the next cycle (latency 1 after the W-th sample).
REQ-021 In ACC with flush=1 and cnt>0 (counting any sample accepted in the same cycle), the block SHALL emit the partial window as in REQ-020.
REQ-022 In ACC with flush=1, cnt=0, and no sample accepted, flush SHALL be ignored.
REQ-023 Simultaneous flush and accepted sample: the sample SHALL be included in the emitted window.
REQ-024 In HOLD, out_* SHALL stay stable and out_valid SHALL stay 1 until out_ready=1.
REQ-025 On a HOLD cycle with out_ready=1, the block SHALL:
- clear sum and cnt to 0;
- set out_valid to 0 on the next cycle;
- return to ACC.
No sample is accepted in that cycle.
REQ-026 flush in HOLD SHALL be ignored.
REQ-027 out_sum SHALL be computed at full N+LOG2W width, so overflow is impossible (max W*(2**N-1)).
REQ-028 The block SHALL contain no combinational path from in_valid or out_ready to any output.

Reset
REQ-029 When rst_n=0 at a rising edge:
- state SHALL be ACC;
- sum, cnt, out_sum, out_min, out_max, out_cnt and out_valid SHALL be 0;
- in_ready SHALL be 1 from the next cycle.
REQ-030 Reset SHALL take precedence over every other input, including mid-window and during HOLD; any partial window is discarded.

Verification
REQ-031 Full window: samples 10,20,30,40,50,60,70,80 on consecutive cycles, out_ready=1 -> one cycle after 80, out_valid=1 with sum=360, min=10, max=80, cnt=8; next cycle out_valid=0 and in_ready=1.
REQ-032 Backpressure: same stream, out_ready=0 for 5 cycles, then 1 -> out_* stable and in_ready=0 throughout HOLD; a stalled in_valid sample 99 is accepted only after return to ACC.
REQ-033 Flush: samples 5,7 then 2 with flush=1 in the same cycle -> sum=14, min=2, max=7, cnt=3; flush with cnt=0 -> no out_valid.
REQ-034 Width extremes: eight samples of 1023 -> sum=8184, min=max=1023, cnt=8; a following window of eight 0 samples -> sum=0, min=max=0.
REQ-035 Reset mid-operation: rst_n=0 after 4 samples, then 8 samples of value 3 -> sum=24, cnt=8; the first 4 samples are not included.
REQ-036 Reset during HOLD -> out_valid=0 on the next cycle, and a new window starts clean.
